// File: rtl/camera_pkg.sv
// Shared types and constants for the camera control path (SCCB master and its sequencer).
package camera_pkg;
  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} sccb_state_t;

  localparam logic [7:0] OV7670_WR_ID        = 8'h42;
  localparam int         SCCB_BITS_PER_PHASE = 9;
  localparam int         SCCB_PHASES         = 3;
endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit timebase: one-cycle tick every Q clocks, realigned by restart.
module sccb_tick_gen #(
  parameter int Q = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(Q);

  logic [W-1:0] cnt;

  // The restart cycle itself counts as the first clock of quarter 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (restart) cnt <= W'(1);
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == W'(Q - 1));
endmodule

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: {id, addr, data} -> start, 27 bits, stop, done pulse.
// Define SCCB_ACK_CHECK_EN to add siod_in sampling of don't-care bits and a sticky nack output.
module sccb_write_master
  import camera_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int SCCB_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] id,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       sioc,
  output logic       siod,
  output logic       siod_oe
`ifdef SCCB_ACK_CHECK_EN
  ,
  input  logic       siod_in,
  output logic       nack
`endif
);
  localparam int Q = CLK_FREQ / (4 * SCCB_FREQ);

  sccb_state_t state, state_nx;
  logic [1:0]  qidx, qidx_nx;
  logic [3:0]  bitcnt, bitcnt_nx;
  logic [1:0]  phase, phase_nx;
  logic [23:0] shreg, shreg_nx;
  logic        sioc_nx, siod_nx, oe_nx;
  logic        tick, accept, last_bit;

  assign ready    = (state == IDLE);
  assign done     = (state == DONE);
  assign accept   = start && ready;
  assign last_bit = (bitcnt == 4'(SCCB_BITS_PER_PHASE - 1));

  sccb_tick_gen #(.Q(Q)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(accept),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      qidx    <= '0;
      bitcnt  <= '0;
      phase   <= '0;
      shreg   <= '0;
      sioc    <= 1'b1;
      siod    <= 1'b1;
      siod_oe <= 1'b1;
    end else begin
      state   <= state_nx;
      qidx    <= qidx_nx;
      bitcnt  <= bitcnt_nx;
      phase   <= phase_nx;
      shreg   <= shreg_nx;
      sioc    <= sioc_nx;
      siod    <= siod_nx;
      siod_oe <= oe_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    qidx_nx   = qidx;
    bitcnt_nx = bitcnt;
    phase_nx  = phase;
    shreg_nx  = shreg;
    sioc_nx   = sioc;
    siod_nx   = siod;
    oe_nx     = siod_oe;
    case (state)
      IDLE: if (start) begin
        state_nx  = START;
        shreg_nx  = {id, addr, data};
        qidx_nx   = '0;
        bitcnt_nx = '0;
        phase_nx  = '0;
        sioc_nx   = 1'b1;
        siod_nx   = 1'b0;
        oe_nx     = 1'b1;
      end
      START: if (tick) begin
        qidx_nx = qidx + 1'b1;
        if (qidx == 2'd1) begin
          state_nx = BIT;
          qidx_nx  = '0;
          sioc_nx  = 1'b0;
          siod_nx  = shreg[23];
        end
      end
      BIT: if (tick) begin
        qidx_nx = qidx + 1'b1;
        if (qidx == 2'd1) sioc_nx = 1'b1;
        if (qidx == 2'd3) begin
          // End of bit: siod takes the next bit's value together with the sioc fall.
          sioc_nx = 1'b0;
          if (last_bit) begin
            bitcnt_nx = '0;
            siod_nx   = shreg[23];
            oe_nx     = 1'b1;
            if (phase == 2'(SCCB_PHASES - 1)) begin
              state_nx = STOP;
              siod_nx  = 1'b0;
            end else begin
              phase_nx = phase + 1'b1;
            end
          end else begin
            shreg_nx  = shreg << 1;
            bitcnt_nx = bitcnt + 1'b1;
            if (bitcnt == 4'(SCCB_BITS_PER_PHASE - 2)) begin
              siod_nx = 1'b1;
              oe_nx   = 1'b0;
            end else begin
              siod_nx = shreg[22];
            end
          end
        end
      end
      STOP: if (tick) begin
        qidx_nx = qidx + 1'b1;
        if (qidx == 2'd0) sioc_nx = 1'b1;
        if (qidx == 2'd1) siod_nx = 1'b1;
        if (qidx == 2'd3) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef SCCB_ACK_CHECK_EN
  logic flag, flag_nx;

  // Slave pulls siod low on the don't-care bit to acknowledge; a high sample is a nack.
  always_comb begin
    flag_nx = flag;
    if (accept) flag_nx = 1'b0;
    if (state == BIT && tick && qidx == 2'd2 && last_bit && siod_in) flag_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag <= 1'b0;
    else        flag <= flag_nx;
  end

  assign nack = flag;
`endif
endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master at Q=10 (4 MHz clk, 100 kHz sioc).
module tb_sccb_write_master;
  import camera_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] id = '0, addr = '0, data = '0;
  logic       ready, done, sioc, siod, siod_oe;
`ifdef SCCB_ACK_CHECK_EN
  logic       siod_in = 1'b0, nack;
  bit         inj = 1'b0;
`endif

  int ntests = 0, nfail = 0;
  int cyc = 0, dcnt = 0, acnt = 0, cap_acc = 0, rcnt = 0;
  int t_acc = 0, t_done = 0, t1 = 0, n0 = 0, a0 = 0;
  logic [26:0] cap_d = '0, cap_oe = '0;

  always #5 clk = ~clk;

  sccb_write_master #(.CLK_FREQ(4_000_000), .SCCB_FREQ(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .id(id), .addr(addr), .data(data),
    .ready(ready), .done(done), .sioc(sioc), .siod(siod), .siod_oe(siod_oe)
`ifdef SCCB_ACK_CHECK_EN
    , .siod_in(siod_in), .nack(nack)
`endif
  );

  always @(posedge clk) cyc++;

  // Times are posedge indices: accept edge, and the edge at which a consumer samples done.
  always @(negedge clk) begin
    if (rst_n && start && ready) begin acnt++; t_acc = cyc + 1; end
    if (done) begin dcnt++; t_done = cyc + 1; end
  end

  always @(sioc) begin
    if (sioc) begin
      if (cap_acc != acnt) begin cap_acc = acnt; rcnt = 0; end
      if (rcnt < 27) begin
        cap_d  = {cap_d[25:0], siod};
        cap_oe = {cap_oe[25:0], siod_oe};
        rcnt++;
      end
`ifdef SCCB_ACK_CHECK_EN
      if (inj && rcnt == 18) siod_in = 1'b1;
    end else begin
      siod_in = 1'b0;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [7:0] i, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    id = i; addr = a; data = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; id = '1; addr = '1; data = '1;
  endtask

  task automatic wait_done(input int base, input string tag);
    int k = 0;
    while (dcnt == base && k < 3000) begin @(negedge clk); #1; k++; end
    chk({tag, "_timeout"}, 32'(dcnt != base), 32'd1);
  endtask

  task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] d);
    logic [26:0] ed, eo;
    ed = {OV7670_WR_ID, 1'b1, a, 1'b1, d, 1'b1};
    eo = {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
    chk({tag, "_nbits"}, 32'(rcnt), 32'd27);
    chk({tag, "_siod"}, 32'(cap_d), 32'(ed));
    chk({tag, "_oe"}, 32'(cap_oe), 32'(eo));
  endtask

  initial begin
    // Reset state
    #23;
    chk("rst_lines", {28'd0, ready, sioc, siod, siod_oe}, 32'hF);
    chk("rst_done", 32'(done), 32'd0);
`ifdef SCCB_ACK_CHECK_EN
    chk("rst_nack", 32'(nack), 32'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_lines", {28'd0, ready, sioc, siod, done}, 32'hE);

    // Single write; inputs scrambled after accept
    go(OV7670_WR_ID, 8'h12, 8'h80);
    chk("start_cond", {29'd0, ready, sioc, siod}, 32'h2);
    wait_done(0, "w1");
    chk("w1_latency", 32'(t_done - t_acc), 32'd1140);
    frame("w1", 8'h12, 8'h80);
    @(negedge clk); #1;
    chk("w1_after", {30'd0, done, ready}, 32'h1);
    chk("w1_dcnt", 32'(dcnt), 32'd1);

    // Start pulse mid-transaction is ignored
    go(OV7670_WR_ID, 8'h0A, 8'h55);
    repeat (500) @(posedge clk);
    #1 start = 1'b1; id = 8'h99; addr = 8'h99; data = 8'h99;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1, "w2");
    chk("w2_latency", 32'(t_done - t_acc), 32'd1140);
    frame("w2", 8'h0A, 8'h55);
    repeat (60) @(negedge clk);
    chk("w2_one_done", 32'(dcnt), 32'd2);
    chk("w2_acnt", 32'(acnt), 32'd2);
    chk("w2_idle", {30'd0, ready, sioc}, 32'h3);

    // Back-to-back with start held high
    @(posedge clk); #1;
    id = OV7670_WR_ID; addr = 8'h11; data = 8'hC3; start = 1'b1;
    n0 = dcnt; a0 = acnt;
    wait_done(n0, "b1");
    t1 = t_done;
    chk("b1_latency", 32'(t_done - t_acc), 32'd1140);
    frame("b1", 8'h11, 8'hC3);
    for (int k = 0; k < 20 && acnt != a0 + 2; k++) @(negedge clk);
    @(posedge clk); #1 start = 1'b0;
    chk("b2_accept_gap", 32'(t_acc - t1), 32'd1);
    wait_done(n0 + 1, "b2");
    chk("b2_spacing", 32'(t_done - t1), 32'd1141);
    frame("b2", 8'h11, 8'hC3);

    // Reset during phase 2, then a clean write
    go(OV7670_WR_ID, 8'h3A, 8'h04);
    for (int k = 0; k < 3000 && !(cap_acc == acnt && rcnt >= 20); k++) @(negedge clk);
    chk("r_in_phase2", 32'(rcnt), 32'd20);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("r_async_lines", {28'd0, ready, sioc, siod, siod_oe}, 32'hF);
    @(posedge clk); #1 rst_n = 1'b1;
    n0 = dcnt;
    repeat (1200) @(negedge clk);
    chk("r_no_done", 32'(dcnt), 32'(n0));
    go(OV7670_WR_ID, 8'h3A, 8'h04);
    wait_done(n0, "r2");
    chk("r2_latency", 32'(t_done - t_acc), 32'd1140);
    frame("r2", 8'h3A, 8'h04);

`ifdef SCCB_ACK_CHECK_EN
    inj = 1'b1;
    n0 = dcnt;
    go(OV7670_WR_ID, 8'h40, 8'h01);
    wait_done(n0, "n1");
    inj = 1'b0;
    chk("n1_nack", 32'(nack), 32'd1);
    go(OV7670_WR_ID, 8'h40, 8'h02);
    wait_done(n0 + 1, "n2");
    chk("n2_nack", 32'(nack), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
